// File: rtl/l5_corr_dump_axis_pkg.sv
// rtl/l5_corr_dump_axis_pkg.sv - shared constants and FSM encodings for the correlator dump block
package l5_corr_dump_axis_pkg;

    localparam logic [7:0] HDR_MAGIC   = 8'hA5;
    localparam int         FRAME_WORDS = 10;
    localparam logic [3:0] W_LAST_CORR = 4'd8;
    localparam logic [3:0] W_STATUS    = 4'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        CAPTURE
    } run_state_t;

    typedef enum logic {
        OUT_IDLE,
        OUT_SEND
    } out_state_t;

endpackage

// File: rtl/corr_frame_buf.sv
// rtl/corr_frame_buf.sv - one-deep snapshot buffer and 10-word AXI-Stream frame serialiser
module corr_frame_buf
    import l5_corr_dump_axis_pkg::*;
#(
    parameter int DSIZE = 32,
    parameter int CNT_W = 24
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cap_i,
    input  logic [DSIZE-1:0] corr_i [8],
    input  logic [CNT_W-1:0] period_i,
    input  logic             overflow_i,
    input  logic             sample_lost_i,
    input  logic [CNT_W-1:0] drop_cnt_i,
    output logic             full_o,
    output logic [DSIZE-1:0] tdata_o,
    output logic             tvalid_o,
    input  logic             tready_i,
    output logic             tlast_o
);

    out_state_t       state_q;
    logic [3:0]       idx_q;
    logic [DSIZE-1:0] snap_q [8];
    logic [DSIZE-1:0] tdata_q;
    logic             tlast_q;

    // Status is sampled when word 9 is loaded so it stays stable under backpressure.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= OUT_IDLE;
            idx_q   <= '0;
            tdata_q <= '0;
            tlast_q <= 1'b0;
        end else begin
            case (state_q)
                OUT_IDLE: begin
                    if (cap_i) begin
                        snap_q  <= corr_i;
                        tdata_q <= {HDR_MAGIC, period_i};
                        tlast_q <= 1'b0;
                        idx_q   <= '0;
                        state_q <= OUT_SEND;
                    end
                end
                OUT_SEND: begin
                    if (tready_i) begin
                        if (idx_q == W_STATUS) begin
                            state_q <= OUT_IDLE;
                            idx_q   <= '0;
                            tdata_q <= '0;
                            tlast_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                            if (idx_q == W_LAST_CORR) begin
                                tdata_q <= {overflow_i, sample_lost_i,
                                            {(DSIZE - CNT_W - 2){1'b0}}, drop_cnt_i};
                                tlast_q <= 1'b1;
                            end else begin
                                tdata_q <= snap_q[idx_q[2:0]];
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign full_o   = (state_q == OUT_SEND);
    assign tvalid_o = (state_q == OUT_SEND);
    assign tdata_o  = tdata_q;
    assign tlast_o  = tlast_q;

endmodule

// File: rtl/l5_corr_dump_axis.sv
// rtl/l5_corr_dump_axis.sv - coherent-period counter, accumulator clear and snapshot dump top
module l5_corr_dump_axis
    import l5_corr_dump_axis_pkg::*;
#(
    parameter int DSIZE = 32,
    parameter int CNT_W = 24
) (
    input  logic             axis_aclk,
    input  logic             axis_reset,
    input  logic             i_start_tracking_valid,
    input  logic             i_stop,
    input  logic             i_mixed_signal_valid,
    input  logic [CNT_W-1:0] i_samples_per_period,
    input  logic [DSIZE-1:0] i_iE,
    input  logic [DSIZE-1:0] i_qE,
    input  logic [DSIZE-1:0] i_iP,
    input  logic [DSIZE-1:0] i_qP,
    input  logic [DSIZE-1:0] i_iL,
    input  logic [DSIZE-1:0] i_qL,
    input  logic [DSIZE-1:0] i_iPilot,
    input  logic [DSIZE-1:0] i_qPilot,
    output logic             o_accum_rstn,
    output logic [DSIZE-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             o_overflow,
    output logic             o_sample_lost,
    output logic             o_busy
);

    run_state_t       state_q;
    logic [CNT_W-1:0] sample_cnt_q;
    logic [CNT_W-1:0] period_cnt_q;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] n_q;
    logic             stop_seen_q;
    logic             accum_rstn_q;
    logic             overflow_q;
    logic             lost_q;
    logic             buf_full;
    logic             cap;
    logic [DSIZE-1:0] corr [8];

    assign corr[0] = i_iE;
    assign corr[1] = i_qE;
    assign corr[2] = i_iP;
    assign corr[3] = i_qP;
    assign corr[4] = i_iL;
    assign corr[5] = i_qL;
    assign corr[6] = i_iPilot;
    assign corr[7] = i_qPilot;

    assign cap = (state_q == CAPTURE) && !buf_full;

    // accum_rstn_q is low for the cycle after any transition into ARM, CAPTURE or a stop-to-IDLE.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            period_cnt_q <= '0;
            drop_cnt_q   <= '0;
            n_q          <= '0;
            stop_seen_q  <= 1'b0;
            accum_rstn_q <= 1'b1;
            overflow_q   <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            accum_rstn_q <= 1'b1;
            if (i_stop) stop_seen_q <= 1'b1;
            if (i_mixed_signal_valid && (state_q == ARM || state_q == CAPTURE)) lost_q <= 1'b1;
            if (state_q == CAPTURE && buf_full) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
            if (i_start_tracking_valid) begin
                state_q      <= ARM;
                accum_rstn_q <= 1'b0;
                overflow_q   <= 1'b0;
                lost_q       <= 1'b0;
                drop_cnt_q   <= '0;
                stop_seen_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: stop_seen_q <= 1'b0;
                    ARM: begin
                        sample_cnt_q <= '0;
                        period_cnt_q <= '0;
                        n_q          <= i_samples_per_period;
                        state_q      <= RUN;
                    end
                    RUN: begin
                        if (i_mixed_signal_valid && sample_cnt_q == n_q - CNT_W'(1)) begin
                            sample_cnt_q <= '0;
                            accum_rstn_q <= 1'b0;
                            state_q      <= CAPTURE;
                        end else if (i_stop || stop_seen_q) begin
                            accum_rstn_q <= 1'b0;
                            state_q      <= IDLE;
                        end else if (i_mixed_signal_valid) begin
                            sample_cnt_q <= sample_cnt_q + CNT_W'(1);
                        end
                    end
                    CAPTURE: begin
                        period_cnt_q <= period_cnt_q + CNT_W'(1);
                        n_q          <= i_samples_per_period;
                        state_q      <= (i_stop || stop_seen_q) ? IDLE : RUN;
                    end
                endcase
            end
        end
    end

    corr_frame_buf #(
        .DSIZE (DSIZE),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk_i         (axis_aclk),
        .reset_i       (axis_reset),
        .cap_i         (cap),
        .corr_i        (corr),
        .period_i      (period_cnt_q),
        .overflow_i    (overflow_q),
        .sample_lost_i (lost_q),
        .drop_cnt_i    (drop_cnt_q),
        .full_o        (buf_full),
        .tdata_o       (m_axis_tdata),
        .tvalid_o      (m_axis_tvalid),
        .tready_i      (m_axis_tready),
        .tlast_o       (m_axis_tlast)
    );

    assign o_accum_rstn  = accum_rstn_q;
    assign o_overflow    = overflow_q;
    assign o_sample_lost = lost_q;
    assign o_busy        = (state_q != IDLE);

endmodule
